// File: rtl/akuma_sprite_pkg.sv
// -----------------------------------------------------------------------------
// akuma_sprite_pkg
// Shared types and constants for the Akuma sprite address path.
//   anim_state_t : animation sequencer state (IDLE / PLAY)
//   *_DFLT       : default sprite geometry and animation timing
//   FRAME_SIZE   : ROM words occupied by one animation frame
//   SCREEN_W/H   : visible raster size
// -----------------------------------------------------------------------------
package akuma_sprite_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } anim_state_t;

  localparam int SPR_W_DFLT      = 67;
  localparam int SPR_H_DFLT      = 82;
  localparam int NUM_FRAMES_DFLT = 4;
  localparam int HOLD_DFLT       = 6;
  localparam int ADDR_W_DFLT     = 15;

  localparam int FRAME_SIZE = SPR_W_DFLT * SPR_H_DFLT;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/akuma_anim_seq.sv
// -----------------------------------------------------------------------------
// akuma_anim_seq
// Animation sequencer: IDLE/PLAY FSM, per-frame hold counter, trigger latch
// and the running ROM base address of the current animation frame.
// Ports:
//   vga_clk      in   pixel clock
//   reset        in   synchronous, active-high
//   frame_start  in   one-cycle pulse at the start of each video frame
//   trigger      in   animation start request (level or pulse)
//   busy         out  animation playing
//   anim_frame   out  current animation frame index
//   frame_base   out  ROM address of word 0 of the current animation frame
// -----------------------------------------------------------------------------
module akuma_anim_seq
  import akuma_sprite_pkg::*;
#(
  parameter int NUM_FRAMES  = NUM_FRAMES_DFLT,
  parameter int HOLD        = HOLD_DFLT,
  parameter int ADDR_W      = ADDR_W_DFLT,
  parameter int FRAME_WORDS = FRAME_SIZE
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          trigger,
  output logic                          busy,
  output logic [$clog2(NUM_FRAMES)-1:0] anim_frame,
  output logic [ADDR_W-1:0]             frame_base
);

  localparam int AF_W = $clog2(NUM_FRAMES);
  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [AF_W-1:0]   FRAME_LAST = AF_W'(NUM_FRAMES - 1);
  localparam logic [HC_W-1:0]   HOLD_LAST  = HC_W'(HOLD - 1);
  localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(FRAME_WORDS);

  anim_state_t       state_r;
  anim_state_t       state_s;
  logic              pending_r;
  logic [HC_W-1:0]   hold_r;
  logic [AF_W-1:0]   anim_frame_r;
  logic [ADDR_W-1:0] frame_base_r;

  logic start_s;
  logic tick_s;
  logic adv_s;
  logic done_s;

  // FSM state register
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = PLAY;
        end else begin
          state_s = IDLE;
        end
      end
      PLAY: begin
        if (done_s) begin
          state_s = IDLE;
        end else begin
          state_s = PLAY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM decode: start request, frame-boundary tick, frame advance and finish
  always_comb begin
    start_s = 1'b0;
    tick_s  = 1'b0;
    adv_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // a trigger arriving together with frame_start starts on that edge
        start_s = frame_start & (pending_r | trigger);
      end
      PLAY: begin
        tick_s = frame_start;
        if (hold_r == HOLD_LAST) begin
          adv_s  = frame_start & (anim_frame_r != FRAME_LAST);
          done_s = frame_start & (anim_frame_r == FRAME_LAST);
        end else begin
          adv_s  = 1'b0;
          done_s = 1'b0;
        end
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Trigger latch: remembers a request made between frame_start pulses
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pending_r <= 1'b0;
    end else if ((state_r == IDLE) && !start_s) begin
      pending_r <= pending_r | trigger;
    end else begin
      pending_r <= 1'b0;
    end
  end

  // Hold counter, frame index and frame base; base accumulates instead of multiplying
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hold_r       <= '0;
      anim_frame_r <= '0;
      frame_base_r <= '0;
    end else if (start_s || done_s) begin
      hold_r       <= '0;
      anim_frame_r <= '0;
      frame_base_r <= '0;
    end else if (adv_s) begin
      hold_r       <= '0;
      anim_frame_r <= anim_frame_r + AF_W'(1);
      frame_base_r <= frame_base_r + FRAME_STEP;
    end else if (tick_s) begin
      hold_r       <= hold_r + HC_W'(1);
    end
  end

  assign busy       = (state_r == PLAY);
  assign anim_frame = anim_frame_r;
  assign frame_base = frame_base_r;

endmodule

// File: rtl/akuma_anim_addr_gen.sv
// -----------------------------------------------------------------------------
// akuma_anim_addr_gen
// Turns the raster position into a sprite ROM address and a sprite_on flag for
// a triggered multi-frame animation. Sprite position and facing are sampled
// once per video frame so a moving sprite never tears mid-frame.
// Build option: define AKUMA_FLIP_EN to enable horizontal mirroring through
// facing_left; without it facing_left is ignored.
// Ports:
//   vga_clk      in   pixel clock
//   reset        in   synchronous, active-high
//   DrawX/DrawY  in   current raster column / row
//   frame_start  in   one-cycle pulse at the start of each video frame
//   trigger      in   animation start request (level or pulse)
//   pos_x/pos_y  in   sprite left / top edge
//   facing_left  in   mirror the sprite horizontally
//   rom_address  out  sprite ROM address, 1 cycle after DrawX/DrawY
//   sprite_on    out  pixel lies inside the sprite box, aligned to rom_address
//   busy         out  animation playing
//   anim_frame   out  current animation frame index
// -----------------------------------------------------------------------------
module akuma_anim_addr_gen
  import akuma_sprite_pkg::*;
#(
  parameter int SPR_W      = SPR_W_DFLT,
  parameter int SPR_H      = SPR_H_DFLT,
  parameter int NUM_FRAMES = NUM_FRAMES_DFLT,
  parameter int HOLD       = HOLD_DFLT,
  parameter int ADDR_W     = ADDR_W_DFLT
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          frame_start,
  input  logic                          trigger,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  input  logic                          facing_left,
  output logic [ADDR_W-1:0]             rom_address,
  output logic                          sprite_on,
  output logic                          busy,
  output logic [$clog2(NUM_FRAMES)-1:0] anim_frame
);

  localparam logic signed [10:0] SPR_W_S    = 11'(SPR_W);
  localparam logic signed [10:0] SPR_H_S    = 11'(SPR_H);
  localparam logic [ADDR_W-1:0]  ROW_STRIDE = ADDR_W'(SPR_W);
  localparam logic [9:0]         X_LIMIT    = 10'(SCREEN_W);
  localparam logic [9:0]         Y_LIMIT    = 10'(SCREEN_H);

  logic [ADDR_W-1:0] frame_base_s;

  logic [9:0]        px_r;
  logic [9:0]        py_r;

  logic signed [10:0] col_s;
  logic signed [10:0] row_s;
  logic signed [10:0] colm_s;
  logic               inside_s;
  logic [ADDR_W-1:0]  addr_s;

  logic [ADDR_W-1:0]  rom_address_r;
  logic               sprite_on_r;

  akuma_anim_seq #(
    .NUM_FRAMES  (NUM_FRAMES),
    .HOLD        (HOLD),
    .ADDR_W      (ADDR_W),
    .FRAME_WORDS (SPR_W * SPR_H)
  ) u_seq (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .frame_start (frame_start),
    .trigger     (trigger),
    .busy        (busy),
    .anim_frame  (anim_frame),
    .frame_base  (frame_base_s)
  );

  // Position snapshot taken once per video frame
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      px_r <= 10'd0;
      py_r <= 10'd0;
    end else if (frame_start) begin
      px_r <= pos_x;
      py_r <= pos_y;
    end
  end

`ifdef AKUMA_FLIP_EN
  logic facing_r;

  // Facing snapshot taken once per video frame
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      facing_r <= 1'b0;
    end else if (frame_start) begin
      facing_r <= facing_left;
    end
  end
`else
  logic unused_s;
  assign unused_s = facing_left;
`endif

  // Per-pixel offset into the sprite box, bounds test and ROM address
  always_comb begin
    col_s = $signed({1'b0, DrawX}) - $signed({1'b0, px_r});
    row_s = $signed({1'b0, DrawY}) - $signed({1'b0, py_r});

    // raster limits clip sprites hanging off the right/bottom edge
    inside_s = (col_s >= 11'sd0) && (col_s < SPR_W_S) &&
               (row_s >= 11'sd0) && (row_s < SPR_H_S) &&
               (DrawX < X_LIMIT) && (DrawY < Y_LIMIT);

`ifdef AKUMA_FLIP_EN
    if (facing_r) begin
      colm_s = SPR_W_S - 11'sd1 - col_s;
    end else begin
      colm_s = col_s;
    end
`else
    colm_s = col_s;
`endif

    // row and column are non-negative whenever the address is used
    addr_s = frame_base_s
           + (ADDR_W'($unsigned(row_s)) * ROW_STRIDE)
           + ADDR_W'($unsigned(colm_s));
  end

  // Registered address and sprite_on; outside pixels read address 0
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address_r <= '0;
      sprite_on_r   <= 1'b0;
    end else if (inside_s) begin
      rom_address_r <= addr_s;
      sprite_on_r   <= 1'b1;
    end else begin
      rom_address_r <= '0;
      sprite_on_r   <= 1'b0;
    end
  end

  assign rom_address = rom_address_r;
  assign sprite_on   = sprite_on_r;

endmodule

// File: tb/tb_akuma_anim_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_akuma_anim_addr_gen
// Scoreboard bench: each driven pixel pushes the expected registered outputs
// computed by a behavioural model; they are popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_akuma_anim_addr_gen;

  localparam int SPR_W      = 67;
  localparam int SPR_H      = 82;
  localparam int NUM_FRAMES = 4;
  localparam int HOLD       = 6;
  localparam int ADDR_W     = 15;
  localparam int FRM_WORDS  = SPR_W * SPR_H;

  logic              vga_clk = 1'b0;
  logic              reset;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              frame_start;
  logic              trigger;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              facing_left;
  logic [ADDR_W-1:0] rom_address;
  logic              sprite_on;
  logic              busy;
  logic [1:0]        anim_frame;

  akuma_anim_addr_gen dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .trigger     (trigger),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .facing_left (facing_left),
    .rom_address (rom_address),
    .sprite_on   (sprite_on),
    .busy        (busy),
    .anim_frame  (anim_frame)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int addr;
    int on;
    int bsy;
    int frm;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // behavioural model state
  int m_busy, m_frame, m_hold, m_pend, m_px, m_py, m_face;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_frame = 0; m_hold = 0; m_pend = 0;
    m_px = 0; m_py = 0; m_face = 0;
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("sb_addr",  32'(rom_address), e.addr);
      check("sb_on",    32'(sprite_on),   e.on);
      check("sb_busy",  32'(busy),        e.bsy);
      check("sb_frame", 32'(anim_frame),  e.frm);
    end
  endtask

  // Drive one pixel, predict the registered result, compare after the edge
  task automatic step(input int x, input int y, input bit fs, input bit trig);
    exp_t e;
    int col, row, colm;
    @(negedge vga_clk);
    reset = 1'b0; DrawX = x[9:0]; DrawY = y[9:0];
    frame_start = fs; trigger = trig;
    col  = x - m_px;
    row  = y - m_py;
    colm = col;
`ifdef AKUMA_FLIP_EN
    if (m_face != 0) colm = SPR_W - 1 - col;
`endif
    if (col >= 0 && col < SPR_W && row >= 0 && row < SPR_H && x < 640 && y < 480) begin
      e.addr = m_frame * FRM_WORDS + row * SPR_W + colm;
      e.on   = 1;
    end else begin
      e.addr = 0;
      e.on   = 0;
    end
    if (m_busy == 0) begin
      if (fs && (m_pend != 0 || trig)) begin
        m_busy = 1; m_frame = 0; m_hold = 0; m_pend = 0;
      end else if (trig) begin
        m_pend = 1;
      end
    end else if (fs) begin
      if (m_hold == HOLD - 1) begin
        m_hold = 0;
        if (m_frame == NUM_FRAMES - 1) begin
          m_busy = 0; m_frame = 0;
        end else begin
          m_frame++;
        end
      end else begin
        m_hold++;
      end
    end
    e.bsy = m_busy;
    e.frm = m_frame;
    if (fs) begin
      m_px = int'(pos_x); m_py = int'(pos_y); m_face = int'(facing_left);
    end
    sb_q.push_back(e);
    @(posedge vga_clk);
    #1;
    sb_compare();
  endtask

  task automatic do_reset(input int x, input int y);
    @(negedge vga_clk);
    reset = 1'b1; DrawX = x[9:0]; DrawY = y[9:0];
    frame_start = 1'b0; trigger = 1'b0;
    @(posedge vga_clk);
    #1;
    model_reset();
    sb_q.delete();
    check("rst_addr",  32'(rom_address), 32'd0);
    check("rst_on",    32'(sprite_on),   32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_frame", 32'(anim_frame),  32'd0);
  endtask

  initial begin
    reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; frame_start = 1'b0;
    trigger = 1'b0; pos_x = 10'd100; pos_y = 10'd50; facing_left = 1'b0;
    model_reset();
    do_reset(0, 0);
    do_reset(100, 50);

    // latch position, then probe corners and edges of the box
    step(0, 0, 1'b1, 1'b0);
    step(100, 50, 1'b0, 1'b0);
    check("tp_origin_addr", 32'(rom_address), 32'd0);
    check("tp_origin_on",   32'(sprite_on),   32'd1);
    step(166, 131, 1'b0, 1'b0);
    check("tp_corner_addr", 32'(rom_address), 32'd5493);
    step(99, 50, 1'b0, 1'b0);
    check("tp_left_on", 32'(sprite_on), 32'd0);
    step(100, 132, 1'b0, 1'b0);
    check("tp_below_on", 32'(sprite_on), 32'd0);
    step(167, 60, 1'b0, 1'b0);
    step(133, 90, 1'b0, 1'b0);

    // position change mid-frame must wait for frame_start
    pos_x = 10'd110;
    step(100, 50, 1'b0, 1'b0);
    check("tp_nomove_on", 32'(sprite_on), 32'd1);
    step(0, 0, 1'b1, 1'b0);
    step(110, 50, 1'b0, 1'b0);
    check("tp_moved_addr", 32'(rom_address), 32'd0);
    step(109, 50, 1'b0, 1'b0);

    // sprite partly beyond the right edge: clipped, no wrap
    pos_x = 10'd600;
    step(0, 0, 1'b1, 1'b0);
    step(639, 60, 1'b0, 1'b0);
    step(5, 60, 1'b0, 1'b0);
    pos_x = 10'd100;
    step(0, 0, 1'b1, 1'b0);

`ifdef AKUMA_FLIP_EN
    facing_left = 1'b1;
    step(0, 0, 1'b1, 1'b0);
    step(100, 50, 1'b0, 1'b0);
    check("tp_flip_addr", 32'(rom_address), 32'd66);
    step(166, 50, 1'b0, 1'b0);
    facing_left = 1'b0;
    step(0, 0, 1'b1, 1'b0);
`endif

    // trigger pulse, then the animation runs 4 frames x 6 video frames
    step(0, 0, 1'b0, 1'b1);
    check("tp_pend_busy", 32'(busy), 32'd0);
    step(0, 0, 1'b1, 1'b0);
    check("tp_start_busy", 32'(busy), 32'd1);
    for (int p = 1; p <= 24; p++) begin
      step(0, 0, 1'b1, (p == 10));
      step(100, 50, 1'b0, (p == 3));
      if (p == 6) begin
        check("tp_f1_frame", 32'(anim_frame), 32'd1);
        check("tp_f1_addr",  32'(rom_address), 32'd5494);
      end
      if (p == 12) begin
        check("tp_f2_addr", 32'(rom_address), 32'd10988);
      end
      if (p == 23) begin
        check("tp_last_busy", 32'(busy), 32'd1);
      end
      if (p == 24) begin
        check("tp_end_busy",  32'(busy),       32'd0);
        check("tp_end_frame", 32'(anim_frame), 32'd0);
      end
    end
    step(0, 0, 1'b1, 1'b0);
    check("tp_norestart", 32'(busy), 32'd0);

    // trigger together with frame_start starts on that edge
    step(0, 0, 1'b1, 1'b1);
    check("tp_coinc_busy", 32'(busy), 32'd1);
    for (int p = 1; p <= 12; p++) begin
      step(0, 0, 1'b1, 1'b0);
    end
    step(100, 50, 1'b0, 1'b0);
    check("tp_pre_rst_frame", 32'(anim_frame), 32'd2);

    // reset mid-animation aborts
    do_reset(100, 50);
    step(0, 0, 1'b1, 1'b0);
    check("tp_post_rst_busy", 32'(busy), 32'd0);
    step(100, 50, 1'b0, 1'b0);
    step(120, 70, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
